// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one registered-read RAM port between the PPU, OAM-DMA and CPU.
// A grant is made combinationally in the request cycle; read data comes back one cycle
// later to whichever requester the registered owner tag names.
module vram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ppu_req,
    input  logic [12:0] ppu_addr,
    output logic        ppu_ack,
    output logic        ppu_rvalid,
    output logic [7:0]  ppu_rdata,
    input  logic        dma_req,
    input  logic [12:0] dma_addr,
    output logic        dma_ack,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_lock,
    output logic [12:0] vram_address,
    output logic [7:0]  vram_data,
    output logic        vram_wren,
    input  logic [7:0]  vram_q
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // Owner of the RAM read launched last cycle.  A locked CPU read never touches the
    // RAM and can finish alongside a PPU/DMA read, so it is tracked in its own bit.
    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_PPU    = 2'd1,
        TAG_DMA    = 2'd2,
        TAG_CPU_RD = 2'd3
    } tag_e;

    tag_e          tag_q, tag_d;
    logic          lock_rd_q, lock_rd_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [12:0]   addr_q, addr_d;
    logic [7:0]    ppu_rdata_q, ppu_rdata_d;
    logic [7:0]    dma_rdata_q, dma_rdata_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;

    logic ppu_win, dma_win, cpu_win, cpu_open, cpu_lock_done, starved;

    // Grant selection: PPU always first; CPU jumps ahead of DMA once it has starved.
    always_comb begin
        starved       = (starve_cnt_q == SW'(STARVE_MAX));
        ppu_win       = reset_n & ppu_req;
        cpu_open      = reset_n & cpu_req & ~ppu_lock;
        cpu_lock_done = reset_n & cpu_req & ppu_lock;
        if (starved) begin
            cpu_win = cpu_open & ~ppu_win;
            dma_win = reset_n & dma_req & ~ppu_win & ~cpu_win;
        end else begin
            dma_win = reset_n & dma_req & ~ppu_win;
            cpu_win = cpu_open & ~ppu_win & ~dma_win;
        end
        ppu_ack = ppu_win;
        dma_ack = dma_win;
        cpu_ack = cpu_win | cpu_lock_done;
    end

    // RAM port drive; the address parks on its last value when nobody wins.
    always_comb begin
        if (ppu_win)      addr_d = ppu_addr;
        else if (dma_win) addr_d = dma_addr;
        else if (cpu_win) addr_d = cpu_addr;
        else              addr_d = addr_q;
        vram_address = addr_d;
        vram_wren    = cpu_win & cpu_we;
        vram_data    = vram_wren ? cpu_wdata : 8'h00;
    end

    // Next owner tag, locked-read flag and CPU starvation count.
    always_comb begin
        if (ppu_win)                 tag_d = TAG_PPU;
        else if (dma_win)            tag_d = TAG_DMA;
        else if (cpu_win && !cpu_we) tag_d = TAG_CPU_RD;
        else                         tag_d = TAG_NONE;
        lock_rd_d = cpu_lock_done & ~cpu_we;

        if (!cpu_req || cpu_ack)
            starve_cnt_d = '0;
        else if (!ppu_lock && dma_win)
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
        else
            starve_cnt_d = starve_cnt_q;
    end

    // Read return: one-cycle valid pulse to the tagged owner, data held otherwise.
    always_comb begin
        ppu_rvalid  = (tag_q == TAG_PPU);
        dma_rvalid  = (tag_q == TAG_DMA);
        cpu_rvalid  = (tag_q == TAG_CPU_RD) | lock_rd_q;
        ppu_rdata_d = ppu_rvalid ? vram_q : ppu_rdata_q;
        dma_rdata_d = dma_rvalid ? vram_q : dma_rdata_q;
        if (lock_rd_q)                cpu_rdata_d = 8'hFF;
        else if (tag_q == TAG_CPU_RD) cpu_rdata_d = vram_q;
        else                          cpu_rdata_d = cpu_rdata_q;
        ppu_rdata = ppu_rdata_d;
        dma_rdata = dma_rdata_d;
        cpu_rdata = cpu_rdata_d;
    end

    // State registers; reset drops any in-flight read and clears held data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_q        <= TAG_NONE;
            lock_rd_q    <= 1'b0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            ppu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            tag_q        <= tag_d;
            lock_rd_q    <= lock_rd_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            ppu_rdata_q  <= ppu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

endmodule
